// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
//
// Presents pc_out to instruction memory under a valid/ready handshake.
// Advances by INSTR_BYTES on each accepted fetch and takes absolute or
// PC-relative redirects from the control unit. Redirect targets that are
// not INSTR_BYTES-aligned are rejected and flagged on misalign_err.
// A BOOT/RUN/HALT state machine gates fetch issue.
//
// Optional feature macro: PC_RAS_EN
//   Adds a circular return-address stack (RAS) with call_push / ret_pop
//   ports. Without the macro there are no RAS ports and no RAS storage.

module pc_gen #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_VEC   = '0,
    parameter int               INSTR_BYTES = 4,
    parameter int               RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc_out,
    input  logic            redir_valid,
    input  logic            redir_rel,
    input  logic [XLEN-1:0] redir_base,
    input  logic [XLEN-1:0] redir_off,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted,
    output logic            misalign_err
`ifdef PC_RAS_EN
    ,
    input  logic            call_push,
    input  logic            ret_pop
`endif
);

    // Increment per accepted fetch and mask of the low bits that must be
    // zero in any legal PC. A mask is used instead of a part-select so
    // INSTR_BYTES == 1 (no alignment bits at all) needs no special case.
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic            err_next;

    // Redirects are only honoured once the machine has left BOOT.
    logic            active;
    logic [XLEN-1:0] redir_target;

    // The redirect actually applied this cycle, after the RAS (if present)
    // has had its say.
    logic            eff_valid;
    logic [XLEN-1:0] eff_target;
    logic            eff_aligned;

    // Resolve the raw redirect target; the sum drops its carry on purpose.
    always_comb begin
        active       = (state != ST_BOOT);
        redir_target = redir_rel ? (redir_base + redir_off) : redir_off;
    end

`ifdef PC_RAS_EN
    // Stack pointer addresses the next free slot; the top entry sits one
    // slot below it, modulo RAS_DEPTH. ras_cnt saturates at RAS_DEPTH so
    // a push onto a full stack overwrites the oldest entry.
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_sp;
    logic [PTR_W-1:0] ras_top;
    logic [PTR_W-1:0] ras_sp_inc;
    logic [CNT_W-1:0] ras_cnt;
    logic             ras_empty;
    logic             ras_full;
    logic             push_req;
    logic             do_pop;
    logic             do_push;
    logic             do_swap;
    logic [XLEN-1:0]  ret_addr;

    // Decode the stack operation for this cycle. A pop wins over the
    // regular redirect; a pop with a simultaneous call replaces the top.
    always_comb begin
        ras_empty  = (ras_cnt == '0);
        ras_full   = (ras_cnt == CNT_FULL);
        ras_top    = (ras_sp == '0) ? PTR_LAST : (ras_sp - PTR_W'(1));
        ras_sp_inc = (ras_sp == PTR_LAST) ? '0 : (ras_sp + PTR_W'(1));
        ret_addr   = redir_base + STEP;
        push_req   = active && redir_valid && call_push;
        do_pop     = active && ret_pop && !ras_empty;
        do_swap    = do_pop && push_req;
        do_push    = !do_pop && push_req && ((redir_target & ALIGN_MASK) == '0);
        eff_valid  = do_pop || (active && redir_valid);
        eff_target = do_pop ? ras_mem[ras_top] : redir_target;
    end

    // Stack pointer and occupancy; reset empties the stack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ras_sp  <= '0;
            ras_cnt <= '0;
        end else if (do_swap) begin
            ras_sp  <= ras_sp;
            ras_cnt <= ras_cnt;
        end else if (do_pop) begin
            ras_sp  <= ras_top;
            ras_cnt <= ras_cnt - CNT_W'(1);
        end else if (do_push) begin
            ras_sp  <= ras_sp_inc;
            if (!ras_full) begin
                ras_cnt <= ras_cnt + CNT_W'(1);
            end
        end
    end

    // Stack contents carry no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (do_swap) begin
                ras_mem[ras_top] <= ret_addr;
            end else if (do_push) begin
                ras_mem[ras_sp] <= ret_addr;
            end
        end
    end
`else
    // Without a RAS the applied redirect is simply the incoming one.
    always_comb begin
        eff_valid  = active && redir_valid;
        eff_target = redir_target;
    end
`endif

    // Alignment of whichever target is being applied.
    always_comb begin
        eff_aligned = ((eff_target & ALIGN_MASK) == '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a halt request beats a simultaneous resume.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  state_next = halt_req ? ST_HALT : ST_RUN;
            ST_HALT: state_next = (resume && !halt_req) ? ST_RUN : ST_HALT;
            default: state_next = ST_BOOT;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        fetch_valid = (state == ST_RUN);
        halted      = (state == ST_HALT);
    end

    // Next PC: an aligned redirect wins; a misaligned one freezes the PC
    // (even against a same-cycle handshake) and raises the error pulse;
    // otherwise an accepted fetch steps the PC. The PC is held while a
    // request is outstanding so fetch sees a stable address.
    always_comb begin
        pc_next  = pc_q;
        err_next = 1'b0;
        if (eff_valid) begin
            if (eff_aligned) begin
                pc_next = eff_target;
            end else begin
                err_next = 1'b1;
            end
        end else if (fetch_valid && fetch_ready) begin
            pc_next = pc_q + STEP;
        end
    end

    // PC and error-pulse registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q         <= RESET_VEC;
            misalign_err <= 1'b0;
        end else begin
            pc_q         <= pc_next;
            misalign_err <= err_next;
        end
    end

    assign pc_out = pc_q;

endmodule
